turbo_dec_8bit: RTL and testbench
=================================

Name: turbo_dec_8bit

Overview:
- Hard-decision receive-side companion to the 8-bit turbo encoder (tt_um_turbo_enc_8bit).
- Accepts one coded block as three bytes in sequence: systematic, parity1, parity2.
- Re-encodes the systematic byte bit-serially through both constituent RSC encoders, the second fed via the 8-point interleaver.
- Returns the decoded byte plus per-encoder parity-mismatch flags. Sits behind the same ui/uio pin style as the encoder.

Parameters:
- None. Block length is fixed at 8. Polynomials and interleaver are fixed as given under Behaviour.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- ui_in  input  8  coded byte.
- uio_in  input  8  bit0 in_valid; bits2:1 field (00 systematic, 01 parity1, 10 parity2, 11 reserved); bits7:3 ignored.
- uo_out  output  8  decoded data byte.
- uio_out  output  8  bit0 out_valid, bit1 err_p1, bit2 err_p2, bit3 busy, bit4 proto_err, bits7:5 = 0.

Behaviour:
- Reset (rst=0, asynchronous): state=WAIT_S, all registers and outputs 0. Reset mid-block discards the block; no out_valid is produced for it.
- Code definition:
  - RSC state (s1,s2) starts at 0 per block. Bits are processed LSB first.
  - Per bit: a = u^s1^s2; p = a^s2; then s2<=s1, s1<=a.
  - Parity byte bit i = p at step i.
  - Encoder 2 input at step i is u[bitrev3(i)]: 0,4,2,6,1,5,3,7.
- FSM: WAIT_S -> WAIT_P1 -> WAIT_P2 -> CHECK -> DONE -> WAIT_S.
  - WAIT_S: on in_valid with field 00, latch sys=ui_in, go to WAIT_P1.
  - WAIT_P1: on in_valid with field 01, latch p1, go to WAIT_P2.
  - WAIT_P2: on in_valid with field 10, latch p2, clear both RSC states and the bit counter, go to CHECK.
  - CHECK: exactly 8 cycles; counter 0..7, one bit per cycle for both encoders. Each computed parity bit is compared with the latched bit; any mismatch sets the err_p1 / err_p2 accumulator. After count 7, go to DONE.
  - DONE: out_valid=1 for exactly one cycle; uo_out=sys; err_p1 and err_p2 valid. Return to WAIT_S.
- Latency: if the parity2 byte is accepted on edge k, out_valid is high in the cycle following edge k+9.
- uo_out, err_p1 and err_p2 are registered. They hold their values after DONE until the next DONE or reset.
- busy=1 in CHECK and DONE. in_valid during busy is dropped and raises proto_err.
- proto_err: a one-cycle pulse, the cycle after an in_valid that is dropped. Causes:
  - field does not match the state's expected field;
  - field = 11;
  - any in_valid during busy.
  - The FSM state is unchanged by a dropped word. No sticky state.
- in_valid=0: no action; latched bytes are retained.
- Back-to-back: the next systematic byte is accepted on the first edge after DONE.

Test Plan:
- Reset held low while inputs toggle, then released -> all of uo_out/uio_out = 0; the first accepted field-00 byte moves the FSM out of WAIT_S.
- Send 0x00, 0x00, 0x00 -> out_valid pulse exactly 10 cycles after the parity2 accept edge; uo_out=0x00, err_p1=0, err_p2=0.
- Send 0x01, 0xB7, 0xB7 -> uo_out=0x01, no errors. Send 0x02, 0x6E, 0x70 -> uo_out=0x02, no errors (this vector exercises the interleaver).
- Send 0x01, 0xB6, 0xB7 -> err_p1=1, err_p2=0. Send 0x02, 0x6E, 0x71 -> err_p1=0, err_p2=1.
- Send parity1 while in WAIT_S, field 11, and a byte during CHECK -> proto_err pulses each time. The block in progress still completes with correct results.
- Assert rst during CHECK of 0x01/0xB7/0xB7 -> outputs clear immediately with no out_valid. The block re-sent after reset decodes cleanly.

Source files
------------

// File: rtl/turbo_dec_8bit.sv
// Hard-decision turbo block checker: collects sys/p1/p2 bytes, re-encodes sys through both RSC encoders, flags parity mismatches.
// Latency: out_valid high the cycle after edge k+9 (k = parity2 accept edge); in_valid while busy or with wrong field is dropped with a proto_err pulse.
module turbo_dec_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out
);

    typedef enum logic [2:0] {
        WAIT_S  = 3'd0,
        WAIT_P1 = 3'd1,
        WAIT_P2 = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sys_q, sys_d;
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic       s1a_q, s1a_d, s2a_q, s2a_d;
    logic       s1b_q, s1b_d, s2b_q, s2b_d;
    logic [2:0] cnt_q, cnt_d;
    logic       acc1_q, acc1_d, acc2_q, acc2_d;
    logic [7:0] dout_q, dout_d;
    logic       err1_q, err1_d, err2_q, err2_d;
    logic       out_vld_q, out_vld_d;
    logic       proto_err_q, proto_err_d;

    logic       in_vld;
    logic [1:0] field;
    logic       busy;
    logic [2:0] cnt_rev;
    logic       ua, ub, aa, ab, pa, pb;
    logic       unused_hi;

    assign in_vld    = uio_in[0];
    assign field     = uio_in[2:1];
    assign unused_hi = ^uio_in[7:3];
    assign busy      = (state_q == CHECK) || (state_q == DONE);
    assign cnt_rev   = {cnt_q[0], cnt_q[1], cnt_q[2]};

    // One trellis step of each constituent encoder; encoder 2 reads the bit-reversed index.
    assign ua = sys_q[cnt_q];
    assign ub = sys_q[cnt_rev];
    assign aa = ua ^ s1a_q ^ s2a_q;
    assign ab = ub ^ s1b_q ^ s2b_q;
    assign pa = aa ^ s2a_q;
    assign pb = ab ^ s2b_q;

    always_comb begin
        state_d     = state_q;
        sys_d       = sys_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        s1a_d       = s1a_q;
        s2a_d       = s2a_q;
        s1b_d       = s1b_q;
        s2b_d       = s2b_q;
        cnt_d       = cnt_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        dout_d      = dout_q;
        err1_d      = err1_q;
        err2_d      = err2_q;
        out_vld_d   = 1'b0;
        proto_err_d = 1'b0;

        case (state_q)
            WAIT_S: begin
                if (in_vld) begin
                    if (field == 2'b00) begin
                        sys_d   = ui_in;
                        state_d = WAIT_P1;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            WAIT_P1: begin
                if (in_vld) begin
                    if (field == 2'b01) begin
                        p1_d    = ui_in;
                        state_d = WAIT_P2;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            WAIT_P2: begin
                if (in_vld) begin
                    if (field == 2'b10) begin
                        p2_d    = ui_in;
                        s1a_d   = 1'b0;
                        s2a_d   = 1'b0;
                        s1b_d   = 1'b0;
                        s2b_d   = 1'b0;
                        cnt_d   = 3'd0;
                        acc1_d  = 1'b0;
                        acc2_d  = 1'b0;
                        state_d = CHECK;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                proto_err_d = in_vld;
                s2a_d  = s1a_q;
                s1a_d  = aa;
                s2b_d  = s1b_q;
                s1b_d  = ab;
                acc1_d = acc1_q | (pa != p1_q[cnt_q]);
                acc2_d = acc2_q | (pb != p2_q[cnt_q]);
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                proto_err_d = in_vld;
                dout_d      = sys_q;
                err1_d      = acc1_q;
                err2_d      = acc2_q;
                out_vld_d   = 1'b1;
                state_d     = WAIT_S;
            end
            default: begin
                state_d = WAIT_S;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_S;
            sys_q       <= 8'h00;
            p1_q        <= 8'h00;
            p2_q        <= 8'h00;
            s1a_q       <= 1'b0;
            s2a_q       <= 1'b0;
            s1b_q       <= 1'b0;
            s2b_q       <= 1'b0;
            cnt_q       <= 3'd0;
            acc1_q      <= 1'b0;
            acc2_q      <= 1'b0;
            dout_q      <= 8'h00;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
            out_vld_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sys_q       <= sys_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            s1a_q       <= s1a_d;
            s2a_q       <= s2a_d;
            s1b_q       <= s1b_d;
            s2b_q       <= s2b_d;
            cnt_q       <= cnt_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            dout_q      <= dout_d;
            err1_q      <= err1_d;
            err2_q      <= err2_d;
            out_vld_q   <= out_vld_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign uo_out  = dout_q;
    assign uio_out = {3'b000, proto_err_q, busy, err2_q, err1_q, out_vld_q};

endmodule

// File: tb/tb_turbo_dec_8bit.sv
// Randomized and directed bench for turbo_dec_8bit against a behavioural turbo-code model.
module tb_turbo_dec_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;

    int n_cmp = 0;
    int n_bad = 0;

    turbo_dec_8bit dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RSC code from its recurrence, optionally reading the data in bit-reversed order.
    function automatic logic [7:0] rsc_parity(input logic [7:0] u, input bit interleave);
        logic [7:0] par;
        int s1, s2, a, x, j;
        par = 8'h00;
        s1 = 0;
        s2 = 0;
        for (int i = 0; i < 8; i++) begin
            j = interleave ? (((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)) : i;
            x = int'(u[j]);
            a = (x + s1 + s2) % 2;
            par[i] = 1'((a + s2) % 2);
            s2 = s1;
            s1 = a;
        end
        return par;
    endfunction

    // Presents one word for a single edge, then checks the proto_err response in the following cycle.
    task automatic send_word(input logic [7:0] d, input logic [1:0] f, input logic exp_drop);
        @(negedge clk);
        ui_in  = d;
        uio_in = {5'b00000, f, 1'b1};
        @(negedge clk);
        uio_in = 8'h00;
        ui_in  = $urandom_range(0, 255);
        check_eq("proto_err", 32'(uio_out[4]), 32'(exp_drop));
    endtask

    // Sends a block and checks latency, data and flags; optionally pokes a word during CHECK.
    task automatic run_block(input logic [7:0] s, input logic [7:0] p1, input logic [7:0] p2,
                             input bit poke);
        logic e1, e2;
        int   found;
        e1 = (p1 != rsc_parity(s, 1'b0));
        e2 = (p2 != rsc_parity(s, 1'b1));
        send_word(s, 2'b00, 1'b0);
        send_word(p1, 2'b01, 1'b0);
        send_word(p2, 2'b10, 1'b0);
        check_eq("busy_check", 32'(uio_out[3]), 32'd1);
        found = 0;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (poke && n == 2) begin
                ui_in  = $urandom_range(0, 255);
                uio_in = {5'b00000, 2'($urandom_range(0, 3)), 1'b1};
            end
            if (poke && n == 3) begin
                uio_in = 8'h00;
                check_eq("proto_busy", 32'(uio_out[4]), 32'd1);
            end
            if (uio_out[0] === 1'b1) begin
                found = n;
                break;
            end
        end
        check_eq("latency", 32'(found), 32'd10);
        check_eq("uo_out", 32'(uo_out), 32'(s));
        check_eq("err_p1", 32'(uio_out[1]), 32'(e1));
        check_eq("err_p2", 32'(uio_out[2]), 32'(e2));
        check_eq("hi_zero", 32'(uio_out[7:5]), 32'd0);
        @(negedge clk);
        check_eq("vld_pulse", 32'(uio_out[0]), 32'd0);
        check_eq("hold_uo", 32'(uo_out), 32'(s));
    endtask

    initial begin
        logic [7:0] s, p1, p2;
        int seen;
        rst    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ui_in  = $urandom_range(0, 255);
            uio_in = $urandom_range(0, 255);
        end
        check_eq("rst_uo", 32'(uo_out), 32'd0);
        check_eq("rst_uio", 32'(uio_out), 32'd0);
        uio_in = 8'h00;
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors.
        run_block(8'h00, 8'h00, 8'h00, 1'b0);
        run_block(8'h01, 8'hB7, 8'hB7, 1'b0);
        run_block(8'h02, 8'h6E, 8'h70, 1'b0);
        run_block(8'h01, 8'hB6, 8'hB7, 1'b0);
        run_block(8'h02, 8'h6E, 8'h71, 1'b0);

        // Protocol violations around an otherwise good block.
        send_word(8'h55, 2'b01, 1'b1);
        send_word(8'h55, 2'b11, 1'b1);
        send_word(8'h5A, 2'b00, 1'b0);
        send_word(8'h12, 2'b11, 1'b1);
        send_word(8'h12, 2'b10, 1'b1);
        send_word(rsc_parity(8'h5A, 1'b0), 2'b01, 1'b0);
        send_word(8'h34, 2'b00, 1'b1);
        send_word(rsc_parity(8'h5A, 1'b1), 2'b10, 1'b0);
        seen = 0;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (uio_out[0] === 1'b1) begin
                seen = n;
                break;
            end
        end
        check_eq("pv_latency", 32'(seen), 32'd10);
        check_eq("pv_uo", 32'(uo_out), 32'h5A);
        check_eq("pv_errs", 32'(uio_out[2:1]), 32'd0);
        run_block(8'hC3, rsc_parity(8'hC3, 1'b0), rsc_parity(8'hC3, 1'b1), 1'b1);

        // Reset in the middle of CHECK.
        run_block(8'hFF, rsc_parity(8'hFF, 1'b0), 8'h00, 1'b0);
        send_word(8'h01, 2'b00, 1'b0);
        send_word(8'hB7, 2'b01, 1'b0);
        send_word(8'hB7, 2'b10, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_uo", 32'(uo_out), 32'd0);
        check_eq("midrst_uio", 32'(uio_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (uio_out[0] === 1'b1) seen++;
        end
        check_eq("midrst_novld", 32'(seen), 32'd0);
        run_block(8'h01, 8'hB7, 8'hB7, 1'b0);

        // Random blocks with occasional single-bit parity corruption.
        for (int b = 0; b < 40; b++) begin
            s  = $urandom_range(0, 255);
            p1 = rsc_parity(s, 1'b0);
            p2 = rsc_parity(s, 1'b1);
            if ($urandom_range(0, 2) == 0) p1 = p1 ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) p2 = p2 ^ (8'h01 << $urandom_range(0, 7));
            run_block(s, p1, p2, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
